exception_sequencer: RTL

- Multicycle FSM beside the main control unit that handles the three CPU exceptions: invalid opcode, ALU overflow and divide-by-zero.
- On an exception it pulses the EPC load and takes over the memory address path.
- It fetches the handler vector byte from the fixed addresses 253, 254 or 255 and drives the PC load with that byte zero-extended to 32 bits.
- The control unit stalls while busy is high and resumes fetch after done.

---
 rtl/exception_sequencer_pkg.sv | 26 ++
 rtl/exception_sequencer_exc_priority_enc.sv | 32 +++
 rtl/exception_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer: FSM state encoding,
// cause codes and the default handler vector byte addresses.
package exception_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_WAIT = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OPC  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_DIV0 = 2'd3;

    localparam logic [7:0] DEF_VEC_OPCODE = 8'd253;
    localparam logic [7:0] DEF_VEC_OVF    = 8'd254;
    localparam logic [7:0] DEF_VEC_DIV0   = 8'd255;

    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'd0, b};
    endfunction

endpackage

// File: rtl/exception_sequencer_exc_priority_enc.sv
// Combinational priority encoder: maps the three exception pulses to a cause
// code and a valid flag, opcode winning over overflow winning over div-by-zero.
import exception_sequencer_pkg::*;

module exc_priority_enc (
    input  logic       i_opcode_exc,
    input  logic       i_overflow_exc,
    input  logic       i_divzero_exc,
    output logic       o_valid,
    output logic [1:0] o_cause
);

    // Highest-priority event wins; simultaneous lower events are dropped.
    always_comb begin
        o_valid = 1'b0;
        o_cause = CAUSE_NONE;
        if (i_opcode_exc) begin
            o_valid = 1'b1;
            o_cause = CAUSE_OPC;
        end else if (i_overflow_exc) begin
            o_valid = 1'b1;
            o_cause = CAUSE_OVF;
        end else if (i_divzero_exc) begin
            o_valid = 1'b1;
            o_cause = CAUSE_DIV0;
        end else begin
            o_valid = 1'b0;
            o_cause = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: saves EPC, fetches the handler vector byte from memory
// and loads it into the PC while the main control unit is stalled.
import exception_sequencer_pkg::*;

module exception_sequencer #(
    parameter int         MEM_WAIT   = 2,
    parameter logic [7:0] VEC_OPCODE = DEF_VEC_OPCODE,
    parameter logic [7:0] VEC_OVF    = DEF_VEC_OVF,
    parameter logic [7:0] VEC_DIV0   = DEF_VEC_DIV0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opcode_exc,
    input  logic        overflow_exc,
    input  logic        divzero_exc,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        epc_load,
    output logic        mem_addr_ovr,
    output logic [31:0] mem_addr,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic [1:0]  cause,
    output logic        done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_cause;
    logic [31:0]        r_pc_value;
    logic               w_exc_valid;
    logic [1:0]         w_exc_cause;
    logic               w_accept;
    logic [7:0]         w_vec;
    logic [31:0]        w_load_value;
    logic               w_unused;

    exc_priority_enc u_prio (
        .i_opcode_exc   (opcode_exc),
        .i_overflow_exc (overflow_exc),
        .i_divzero_exc  (divzero_exc),
        .o_valid        (w_exc_valid),
        .o_cause        (w_exc_cause)
    );

    assign w_accept     = (r_state == ST_IDLE) && w_exc_valid;
    assign w_load_value = zext_byte(mem_rdata[7:0]);
    // Only the low byte of the read word carries the vector.
    assign w_unused     = ^mem_rdata[31:8];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; events arriving outside IDLE are ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SAVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SAVE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_LOAD: w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Wait counter, latched cause and held PC vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_cause    <= CAUSE_NONE;
            r_pc_value <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cause <= w_exc_cause;
            end else begin
                r_cause <= r_cause;
            end
            case (r_state)
                ST_SAVE: r_cnt <= '0;
                ST_WAIT: r_cnt <= r_cnt + CNT_W'(1);
                default: r_cnt <= '0;
            endcase
            if (r_state == ST_LOAD) begin
                r_pc_value <= w_load_value;
            end else begin
                r_pc_value <= r_pc_value;
            end
        end
    end

    // Vector byte address for the latched cause.
    always_comb begin
        case (r_cause)
            CAUSE_OPC:  w_vec = VEC_OPCODE;
            CAUSE_OVF:  w_vec = VEC_OVF;
            CAUSE_DIV0: w_vec = VEC_DIV0;
            default:    w_vec = 8'd0;
        endcase
    end

    // Output decode; LOAD forwards the fresh vector so PC sees it in the same cycle.
    always_comb begin
        busy         = 1'b0;
        epc_load     = 1'b0;
        mem_addr_ovr = 1'b0;
        mem_addr     = 32'd0;
        pc_load      = 1'b0;
        pc_value     = r_pc_value;
        cause        = r_cause;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_SAVE: begin
                busy         = 1'b1;
                epc_load     = 1'b1;
                mem_addr_ovr = 1'b1;
                mem_addr     = zext_byte(w_vec);
            end
            ST_WAIT: begin
                busy         = 1'b1;
                mem_addr_ovr = 1'b1;
                mem_addr     = zext_byte(w_vec);
            end
            ST_LOAD: begin
                busy         = 1'b1;
                mem_addr_ovr = 1'b1;
                mem_addr     = zext_byte(w_vec);
                pc_load      = 1'b1;
                pc_value     = w_load_value;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
